// File: rtl/control_ingreso_teclado.sv
// Calculator-style BCD entry controller fed by the keypad driver's key stream.
// Builds an N-digit number with backspace, clear, enter and idle timeout, then offers it via valid/ack.
module control_ingreso_teclado #(
  parameter int N_DIGITOS      = 4,
  parameter int TIMEOUT_CICLOS = 50_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4:0]             digito,
  input  logic                   cambio_digito,
  input  logic                   listo,
  output logic [4*N_DIGITOS-1:0] dato_bcd,
  output logic [2:0]             cant_digitos,
  output logic                   dato_valido,
  output logic                   error,
  output logic                   ocupado
);

  localparam int              ANCHO = 4 * N_DIGITOS;
  localparam int              CW    = $clog2(TIMEOUT_CICLOS);
  localparam logic [CW-1:0]   T_MAX = CW'(TIMEOUT_CICLOS - 1);
  localparam logic [2:0]      N_MAX = 3'(N_DIGITOS);

  localparam logic [4:0] K_BORRAR  = 5'd10;
  localparam logic [4:0] K_ENTER   = 5'd11;
  localparam logic [4:0] K_LIMPIAR = 5'd12;

  typedef enum logic [1:0] {
    VACIO,
    CARGANDO,
    ENTREGA
  } estado_t;

  estado_t          r_estado;
  logic [ANCHO-1:0] r_dato;
  logic [2:0]       r_cant;
  logic             r_valido;
  logic             r_error;
  logic             r_ocupado;
  logic             r_cambio_prev;
  logic [CW-1:0]    r_cont;

  logic       w_evento;
  logic       w_es_digito;
  logic [3:0] w_nibble;
  logic       w_expira;

  // A held strobe counts once: only its rising edge is a key event.
  assign w_evento    = cambio_digito & ~r_cambio_prev;
  assign w_es_digito = (digito < 5'd10);
  assign w_nibble    = digito[3:0];
  assign w_expira    = (r_cont == T_MAX);

  // NOTE: all state lives in one clocked block with non-blocking assignments, so every
  // right-hand side sees the pre-edge value and later assignments in the block override earlier ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_estado      <= VACIO;
      r_dato        <= '0;
      r_cant        <= '0;
      r_valido      <= 1'b0;
      r_error       <= 1'b0;
      r_ocupado     <= 1'b0;
      r_cambio_prev <= 1'b0;
      r_cont        <= '0;
    end else begin
      r_cambio_prev <= cambio_digito;
      r_error       <= 1'b0;

      case (r_estado)
        VACIO: begin
          r_cont <= '0;
          if (w_evento && w_es_digito) begin
            r_dato    <= ANCHO'(w_nibble);
            r_cant    <= 3'd1;
            r_ocupado <= 1'b1;
            r_estado  <= CARGANDO;
          end else if (w_evento && digito == K_ENTER) begin
            r_error <= 1'b1;
          end
        end

        CARGANDO: begin
          if (w_evento && w_es_digito && r_cant < N_MAX) begin
            r_dato <= (r_dato << 4) | ANCHO'(w_nibble);
            r_cant <= r_cant + 3'd1;
            r_cont <= '0;
          end else if (w_evento && w_es_digito) begin
            // Rejected digit is not activity, but on expiry the keystroke still wins.
            r_error <= 1'b1;
            r_cont  <= w_expira ? '0 : r_cont + CW'(1);
          end else if (w_evento && digito == K_BORRAR) begin
            r_dato <= r_dato >> 4;
            r_cant <= r_cant - 3'd1;
            r_cont <= '0;
            if (r_cant == 3'd1) begin
              r_estado  <= VACIO;
              r_ocupado <= 1'b0;
            end
          end else if (w_evento && digito == K_LIMPIAR) begin
            r_dato    <= '0;
            r_cant    <= '0;
            r_cont    <= '0;
            r_ocupado <= 1'b0;
            r_estado  <= VACIO;
          end else if (w_evento && digito == K_ENTER) begin
            r_valido <= 1'b1;
            r_cont   <= '0;
            r_estado <= ENTREGA;
          end else if (w_expira) begin
            r_dato    <= '0;
            r_cant    <= '0;
            r_cont    <= '0;
            r_ocupado <= 1'b0;
            r_estado  <= VACIO;
          end else begin
            r_cont <= r_cont + CW'(1);
          end
        end

        ENTREGA: begin
          r_cont <= '0;
          if (listo) begin
            r_dato    <= '0;
            r_cant    <= '0;
            r_valido  <= 1'b0;
            r_ocupado <= 1'b0;
            r_estado  <= VACIO;
          end
        end

        default: begin
          r_dato    <= '0;
          r_cant    <= '0;
          r_valido  <= 1'b0;
          r_ocupado <= 1'b0;
          r_cont    <= '0;
          r_estado  <= VACIO;
        end
      endcase
    end
  end

  assign dato_bcd     = r_dato;
  assign cant_digitos = r_cant;
  assign dato_valido  = r_valido;
  assign error        = r_error;
  assign ocupado      = r_ocupado;

endmodule

// File: tb/tb_control_ingreso_teclado.sv
// Self-checking bench for control_ingreso_teclado (N_DIGITOS=4, TIMEOUT_CICLOS=20).
// A per-cycle vector table covers the key sequences; hand sequences cover hold, timeout and reset.
module tb_control_ingreso_teclado;

  localparam logic [4:0] K_BOR = 5'd10;
  localparam logic [4:0] K_ENT = 5'd11;
  localparam logic [4:0] K_LIM = 5'd12;
  localparam logic [4:0] K_IGN = 5'd20;

  logic        clk;
  logic        rst;
  logic [4:0]  digito;
  logic        cambio_digito;
  logic        listo;
  logic [15:0] dato_bcd;
  logic [2:0]  cant_digitos;
  logic        dato_valido;
  logic        error;
  logic        ocupado;

  int n_checks = 0;
  int n_fails  = 0;

  control_ingreso_teclado #(
    .N_DIGITOS     (4),
    .TIMEOUT_CICLOS(20)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .digito       (digito),
    .cambio_digito(cambio_digito),
    .listo        (listo),
    .dato_bcd     (dato_bcd),
    .cant_digitos (cant_digitos),
    .dato_valido  (dato_valido),
    .error        (error),
    .ocupado      (ocupado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [4:0]  dig;
    logic        cam;
    logic        lis;
    logic [15:0] dato;
    logic [2:0]  cant;
    logic        val;
    logic        err;
    logic        ocu;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic [4:0] d, input logic c, input logic l,
                              input logic [15:0] e_dato, input logic [2:0] e_cant,
                              input logic e_val, input logic e_err, input logic e_ocu);
    vec_t v;
    v.rst = r; v.dig = d; v.cam = c; v.lis = l;
    v.dato = e_dato; v.cant = e_cant; v.val = e_val; v.err = e_err; v.ocu = e_ocu;
    return v;
  endfunction

  // Drive inputs mid-cycle, let one rising edge sample them, then settle before checking.
  task automatic step(input logic r, input logic [4:0] d, input logic c, input logic l);
    @(negedge clk);
    rst           = r;
    digito        = d;
    cambio_digito = c;
    listo         = l;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] e_dato, input logic [2:0] e_cant,
                       input logic e_val, input logic e_err, input logic e_ocu);
    n_checks++;
    if (dato_bcd !== e_dato || cant_digitos !== e_cant || dato_valido !== e_val ||
        error !== e_err || ocupado !== e_ocu) begin
      n_fails++;
      $display("FAIL %s: got dato=%h cant=%0d valido=%b error=%b ocupado=%b, expected dato=%h cant=%0d valido=%b error=%b ocupado=%b",
               name, dato_bcd, cant_digitos, dato_valido, error, ocupado,
               e_dato, e_cant, e_val, e_err, e_ocu);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; digito = '0; cambio_digito = 1'b0; listo = 1'b0;

    // rst dig cam lis | dato cant val err ocu
    vecs.push_back(mk(1, 0,     0, 0, 16'h0000, 0, 0, 0, 0)); // reset
    vecs.push_back(mk(0, 1,     1, 0, 16'h0001, 1, 0, 0, 1)); // key 1
    vecs.push_back(mk(0, 1,     0, 0, 16'h0001, 1, 0, 0, 1));
    vecs.push_back(mk(0, 2,     1, 0, 16'h0012, 2, 0, 0, 1)); // key 2
    vecs.push_back(mk(0, 2,     0, 0, 16'h0012, 2, 0, 0, 1));
    vecs.push_back(mk(0, 3,     1, 0, 16'h0123, 3, 0, 0, 1)); // key 3
    vecs.push_back(mk(0, 3,     0, 0, 16'h0123, 3, 0, 0, 1));
    vecs.push_back(mk(0, K_ENT, 1, 0, 16'h0123, 3, 1, 0, 1)); // enter
    vecs.push_back(mk(0, K_ENT, 0, 0, 16'h0123, 3, 1, 0, 1));
    vecs.push_back(mk(0, 3,     1, 0, 16'h0123, 3, 1, 0, 1)); // key ignored in ENTREGA
    vecs.push_back(mk(0, 3,     0, 0, 16'h0123, 3, 1, 0, 1));
    vecs.push_back(mk(0, 0,     0, 1, 16'h0000, 0, 0, 0, 0)); // listo
    vecs.push_back(mk(0, 0,     0, 0, 16'h0000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 9,     1, 0, 16'h0009, 1, 0, 0, 1)); // 9
    vecs.push_back(mk(0, 9,     0, 0, 16'h0009, 1, 0, 0, 1));
    vecs.push_back(mk(0, 8,     1, 0, 16'h0098, 2, 0, 0, 1)); // 8
    vecs.push_back(mk(0, 8,     0, 0, 16'h0098, 2, 0, 0, 1));
    vecs.push_back(mk(0, 7,     1, 0, 16'h0987, 3, 0, 0, 1)); // 7
    vecs.push_back(mk(0, 7,     0, 0, 16'h0987, 3, 0, 0, 1));
    vecs.push_back(mk(0, 6,     1, 0, 16'h9876, 4, 0, 0, 1)); // 6
    vecs.push_back(mk(0, 6,     0, 0, 16'h9876, 4, 0, 0, 1));
    vecs.push_back(mk(0, 5,     1, 0, 16'h9876, 4, 0, 1, 1)); // 5 rejected: full
    vecs.push_back(mk(0, 5,     0, 0, 16'h9876, 4, 0, 0, 1)); // error lasts one cycle
    vecs.push_back(mk(0, K_BOR, 1, 0, 16'h0987, 3, 0, 0, 1)); // borrar
    vecs.push_back(mk(0, K_BOR, 0, 0, 16'h0987, 3, 0, 0, 1));
    vecs.push_back(mk(0, K_IGN, 1, 0, 16'h0987, 3, 0, 0, 1)); // ignored code
    vecs.push_back(mk(0, K_IGN, 0, 0, 16'h0987, 3, 0, 0, 1));
    vecs.push_back(mk(0, K_LIM, 1, 0, 16'h0000, 0, 0, 0, 0)); // limpiar
    vecs.push_back(mk(0, K_LIM, 0, 0, 16'h0000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4,     1, 0, 16'h0004, 1, 0, 0, 1)); // 4
    vecs.push_back(mk(0, 4,     0, 0, 16'h0004, 1, 0, 0, 1));
    vecs.push_back(mk(0, K_BOR, 1, 0, 16'h0000, 0, 0, 0, 0)); // borrar -> VACIO
    vecs.push_back(mk(0, K_BOR, 0, 0, 16'h0000, 0, 0, 0, 0));
    vecs.push_back(mk(0, K_BOR, 1, 0, 16'h0000, 0, 0, 0, 0)); // borrar in VACIO: no effect
    vecs.push_back(mk(0, K_BOR, 0, 0, 16'h0000, 0, 0, 0, 0));
    vecs.push_back(mk(0, K_ENT, 1, 0, 16'h0000, 0, 0, 1, 0)); // enter in VACIO: error
    vecs.push_back(mk(0, K_ENT, 0, 0, 16'h0000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,     0, 1, 16'h0000, 0, 0, 0, 0)); // listo in VACIO ignored
    vecs.push_back(mk(0, 0,     0, 0, 16'h0000, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].dig, vecs[i].cam, vecs[i].lis);
      check($sformatf("vec%0d", i), vecs[i].dato, vecs[i].cant, vecs[i].val, vecs[i].err, vecs[i].ocu);
    end

    // Strobe held for 10 cycles with digit 5: a single digit accepted.
    for (int i = 0; i < 10; i++) begin
      step(0, 5, 1, 0);
      check($sformatf("hold%0d", i), 16'h0005, 1, 0, 0, 1);
    end
    step(0, 5, 0, 0);
    check("hold_release", 16'h0005, 1, 0, 0, 1);

    // Timeout: key 7, 19 idle edges keep it; a key on the expiry edge wins.
    step(1, 0, 0, 0);
    check("to_reset", 16'h0000, 0, 0, 0, 0);
    step(0, 7, 1, 0);
    check("to_key7", 16'h0007, 1, 0, 0, 1);
    for (int i = 1; i <= 19; i++) begin
      step(0, 7, 0, 0);
      check($sformatf("to_idle%0d", i), 16'h0007, 1, 0, 0, 1);
    end
    step(0, 1, 1, 0);
    check("to_key_on_expiry", 16'h0071, 2, 0, 0, 1);
    for (int i = 1; i <= 19; i++) begin
      step(0, 1, 0, 0);
      check($sformatf("to_reload%0d", i), 16'h0071, 2, 0, 0, 1);
    end
    step(0, 1, 0, 0);
    check("to_discard", 16'h0000, 0, 0, 0, 0);
    step(0, 1, 0, 0);
    check("to_after", 16'h0000, 0, 0, 0, 0);

    // Reset mid-entry with 0x0042, while a key event is also present.
    step(0, 4, 1, 0);
    step(0, 4, 0, 0);
    step(0, 2, 1, 0);
    step(0, 2, 0, 0);
    check("rst_pre", 16'h0042, 2, 0, 0, 1);
    step(1, 9, 1, 0);
    check("rst_mid_entry", 16'h0000, 0, 0, 0, 0);
    step(0, 9, 0, 0);
    check("rst_mid_entry_after", 16'h0000, 0, 0, 0, 0);

    // Reset mid-handshake.
    step(0, 5, 1, 0);
    step(0, 5, 0, 0);
    step(0, K_ENT, 1, 0);
    check("hs_offer", 16'h0005, 1, 1, 0, 1);
    step(1, K_ENT, 0, 0);
    check("rst_mid_handshake", 16'h0000, 0, 0, 0, 0);
    step(0, 0, 0, 1);
    check("post_rst_listo", 16'h0000, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/control_ingreso_teclado.md
# control_ingreso_teclado

Entry controller that sits between `Driver_teclado` and the consumer logic. It takes the decoded key stream (`digito`, `cambio_digito`) and assembles a multi-digit BCD number in calculator fashion, with backspace, clear-all, enter and inactivity timeout. It delivers the finished number through a valid/acknowledge handshake. The keypad driver is unchanged; this block adds the sequencing the raw key stream lacks.

## Interface
Parameters:
- `N_DIGITOS`, 4: buffer capacity in digits (1..7).
- `TIMEOUT_CICLOS`, 50_000_000: idle cycles in CARGANDO before the buffer is discarded (≥2).

Ports:
- `clk` in 1: single system clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `digito` in 5: key code from the keypad driver. Codes 0–9 are digits, 10 is borrar (backspace), 11 is enter, 12 is limpiar (clear all), 13–31 are ignored.
- `cambio_digito` in 1: key-event strobe from the driver.
- `listo` in 1: consumer acknowledge of the delivered value.
- `dato_bcd` out 4*N_DIGITOS: BCD buffer; nibble 0 (LSB) is the most recent digit.
- `cant_digitos` out 3: number of digits currently held (0..N_DIGITOS).
- `dato_valido` out 1: high while a completed entry is offered.
- `error` out 1: one-cycle pulse on a rejected keystroke.
- `ocupado` out 1: high in CARGANDO or ENTREGA.

## Operation
- Event detection: register `cambio_prev`. An event is `cambio_digito & ~cambio_prev`, so a held strobe counts once. `digito` is sampled in the same cycle as the event.
- States:
  - VACIO: buffer 0, count 0.
  - CARGANDO: 1..N digits held.
  - ENTREGA: value offered.
- VACIO:
  - Digit event: `dato_bcd` becomes {0…, d}, count 1, go to CARGANDO.
  - Enter: `error` pulse, stay.
  - Borrar or limpiar: no effect.
- CARGANDO:
  - Digit with count<N: `dato_bcd` ← (`dato_bcd`<<4) | d, count+1.
  - Digit with count=N: buffer unchanged, `error` pulse.
  - Borrar: `dato_bcd` ← `dato_bcd`>>4 with zero fill, count−1. If count becomes 0, go to VACIO.
  - Limpiar: buffer 0, count 0, go to VACIO.
  - Enter: go to ENTREGA; `dato_valido`=1.
  - Ignored codes: no effect, and the timeout counter is not reloaded.
- Timeout counter:
  - Reloaded to 0 on every accepted event in CARGANDO (digit, borrar, enter).
  - Increments each cycle otherwise.
  - Reaching TIMEOUT_CICLOS−1: clear buffer and go to VACIO, with no `error` pulse.
- ENTREGA:
  - `dato_bcd`, `cant_digitos` and `dato_valido` are held stable.
  - All key events are ignored, with no error.
  - `listo`=1 clears buffer and count, drops `dato_valido`, and goes to VACIO.
  - `listo` in any other state is ignored.
- Reset:
  - `rst`=1 at any edge forces VACIO, `dato_bcd`=0, `cant_digitos`=0, `dato_valido`=0, `error`=0, `ocupado`=0, `cambio_prev`=0, timeout counter 0.
  - This applies mid-entry and mid-handshake.
- Simultaneous events:
  - Timeout expiry and a key event in the same cycle: the key event wins and the counter reloads.
  - `rst` dominates everything.

## Timing
- Event at edge k (strobe and code sampled high): buffer, count and state are updated at edge k, visible after edge k. Zero added latency beyond registering.
- `error` is high for exactly the cycle following edge k.
- `dato_valido` rises after the edge that samples enter. It falls after the edge that samples `listo`=1.
- With N_DIGITOS=4: from the last accepted event to discard takes TIMEOUT_CICLOS edges.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Keys 1,2,3 then enter (1-cycle strobes, 3 idle cycles apart) → `dato_bcd`=0x0123, `cant_digitos`=3, `dato_valido`=1 held until `listo`. The cycle after `listo`=1: everything 0, `ocupado`=0.
- Keys 9,8,7,6,5 → after the 5th key `dato_bcd`=0x9876, `error` high for one cycle. Then borrar → 0x0987, count 3.
- Key 4, borrar, borrar → state VACIO, no error. Enter in VACIO → `error` pulse, `dato_valido` stays 0.
- `cambio_digito` held high 10 cycles with `digito`=5 → exactly one digit accepted (0x0005).
- TIMEOUT_CICLOS=20: key 7 then idle 19 cycles → still 0x0007. Key at cycle 19 → counter reloads. Then 20 idle cycles → buffer 0, VACIO.
- In ENTREGA, send key 3 → value unchanged. Assert `rst` while CARGANDO with 0x0042 → all outputs 0 the next cycle.
